// File: rtl/ptp_cfg_seq.sv
// ptp_cfg_seq: PTP core init sequencer sharing the core register bus with a host port
module ptp_cfg_seq #(
    parameter logic [31:0] TSU_CFG_VAL   = 32'h0000_0001,
    parameter logic [31:0] TICK_INC_VAL  = 32'h1999_999a,
    parameter logic [31:0] NS_OFST_VAL   = 32'h1234_5678,
    parameter logic [47:0] SC_OFST_VAL   = 48'h3ccc_cccc_cccc,
    parameter logic [15:0] TMO_CYC       = 16'd1024,
    parameter logic [7:0]  TSU_BLK_ADDR  = 8'h01,
    parameter logic [7:0]  RTC_BLK_ADDR  = 8'h02,
    parameter logic [7:0]  TSU_CFG_ADDR  = 8'h00,
    parameter logic [7:0]  RTC_CTL_ADDR  = 8'h00,
    parameter logic [7:0]  TICK_INC_ADDR = 8'h04,
    parameter logic [7:0]  NS_OFST_ADDR  = 8'h08,
    parameter logic [7:0]  SC_OFST_ADDR0 = 8'h0c,
    parameter logic [7:0]  SC_OFST_ADDR1 = 8'h10
) (
    input  logic        bus2ip_clk,
    input  logic        bus2ip_rst,
    input  logic        start_i,
    input  logic        master_i,
    input  logic        host_req_i,
    input  logic        host_wr_i,
    input  logic [15:0] host_addr_i,
    input  logic [31:0] host_wdata_i,
    output logic        host_ack_o,
    output logic [31:0] host_rdata_o,
    output logic        reg_req_o,
    output logic        reg_wr_o,
    output logic [15:0] reg_addr_o,
    output logic [31:0] reg_wdata_o,
    input  logic        reg_ack_i,
    input  logic [31:0] reg_rdata_i,
    output logic        seq_busy_o,
    output logic        seq_done_o,
    output logic        seq_err_o
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, DONE, ERR} state_t;

    state_t      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [15:0] tmo_q, tmo_d;
    logic        master_q, master_d, start_pend_q, start_pend_d, host_busy_q, host_busy_d;
    logic        reg_req_q, reg_req_d, reg_wr_q, reg_wr_d, host_ack_q, host_ack_d;
    logic [15:0] reg_addr_q, reg_addr_d;
    logic [31:0] reg_wdata_q, reg_wdata_d, host_rdata_q, host_rdata_d;
    logic        seq_done_q, seq_done_d, seq_err_q, seq_err_d;
    logic [15:0] step_addr;
    logic [31:0] step_data;
    logic        go, ack;
    logic [2:0]  last_step;

    assign go         = (start_i | start_pend_q) & ~host_busy_q;
    assign ack        = reg_ack_i & reg_req_q;
    assign last_step  = master_q ? 3'd5 : 3'd1;
    assign seq_busy_o = (state_q == ISSUE) || (state_q == WAIT) || (state_q == GAP);
    assign reg_req_o    = reg_req_q;
    assign reg_wr_o     = reg_wr_q;
    assign reg_addr_o   = reg_addr_q;
    assign reg_wdata_o  = reg_wdata_q;
    assign host_ack_o   = host_ack_q;
    assign host_rdata_o = host_rdata_q;
    assign seq_done_o   = seq_done_q;
    assign seq_err_o    = seq_err_q;

    // Address/data of the current init step
    always_comb begin
        step_addr = {RTC_BLK_ADDR, RTC_CTL_ADDR};
        step_data = 32'h0000_0001;
        case (step_q)
            3'd0: begin step_addr = {TSU_BLK_ADDR, TSU_CFG_ADDR};  step_data = TSU_CFG_VAL; end
            3'd1: begin step_addr = {RTC_BLK_ADDR, TICK_INC_ADDR}; step_data = TICK_INC_VAL; end
            3'd2: begin step_addr = {RTC_BLK_ADDR, NS_OFST_ADDR};  step_data = NS_OFST_VAL; end
            3'd3: begin step_addr = {RTC_BLK_ADDR, SC_OFST_ADDR0}; step_data = {16'h0000, SC_OFST_VAL[47:32]}; end
            3'd4: begin step_addr = {RTC_BLK_ADDR, SC_OFST_ADDR1}; step_data = SC_OFST_VAL[31:0]; end
            default: ;
        endcase
    end

    // Sequencer FSM plus host pass-through when the sequencer is not running
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        tmo_d        = tmo_q;
        master_d     = master_q;
        start_pend_d = start_pend_q;
        host_busy_d  = host_busy_q;
        reg_req_d    = reg_req_q;
        reg_wr_d     = reg_wr_q;
        reg_addr_d   = reg_addr_q;
        reg_wdata_d  = reg_wdata_q;
        host_ack_d   = 1'b0;
        host_rdata_d = 32'h0;
        seq_done_d   = seq_done_q;
        seq_err_d    = seq_err_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start_i) master_d = master_i;
                if (start_i && host_busy_q) start_pend_d = 1'b1;
                if (go) begin
                    state_d      = ISSUE;
                    step_d       = 3'd0;
                    start_pend_d = 1'b0;
                    seq_done_d   = 1'b0;
                    seq_err_d    = 1'b0;
                end else if (host_busy_q) begin
                    if (ack) begin
                        reg_req_d    = 1'b0;
                        host_busy_d  = 1'b0;
                        host_ack_d   = 1'b1;
                        host_rdata_d = reg_wr_q ? 32'h0 : reg_rdata_i;
                    end
                end else if (host_req_i && !host_ack_q) begin
                    reg_req_d   = 1'b1;
                    reg_wr_d    = host_wr_i;
                    reg_addr_d  = host_addr_i;
                    reg_wdata_d = host_wdata_i;
                    host_busy_d = 1'b1;
                end
            end
            ISSUE: begin
                reg_req_d   = 1'b1;
                reg_wr_d    = 1'b1;
                reg_addr_d  = step_addr;
                reg_wdata_d = step_data;
                tmo_d       = 16'h0;
                state_d     = WAIT;
            end
            WAIT: begin
                if (ack) begin
                    reg_req_d = 1'b0;
                    state_d   = GAP;
                end else if (tmo_q == TMO_CYC - 16'd1) begin
                    reg_req_d = 1'b0;
                    seq_err_d = 1'b1;
                    state_d   = ERR;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            GAP: begin
                if (step_q == last_step) begin
                    seq_done_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    step_d  = step_q + 3'd1;
                    state_d = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any in-flight access
    always_ff @(posedge bus2ip_clk or posedge bus2ip_rst) begin
        if (bus2ip_rst) begin
            state_q      <= IDLE;
            step_q       <= 3'd0;
            tmo_q        <= 16'h0;
            master_q     <= 1'b0;
            start_pend_q <= 1'b0;
            host_busy_q  <= 1'b0;
            reg_req_q    <= 1'b0;
            reg_wr_q     <= 1'b0;
            reg_addr_q   <= 16'h0;
            reg_wdata_q  <= 32'h0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= 32'h0;
            seq_done_q   <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            tmo_q        <= tmo_d;
            master_q     <= master_d;
            start_pend_q <= start_pend_d;
            host_busy_q  <= host_busy_d;
            reg_req_q    <= reg_req_d;
            reg_wr_q     <= reg_wr_d;
            reg_addr_q   <= reg_addr_d;
            reg_wdata_q  <= reg_wdata_d;
            host_ack_q   <= host_ack_d;
            host_rdata_q <= host_rdata_d;
            seq_done_q   <= seq_done_d;
            seq_err_q    <= seq_err_d;
        end
    end
endmodule

// File: tb/tb_ptp_cfg_seq.sv
// tb_ptp_cfg_seq: table-driven and scoreboard bench for the PTP init sequencer
module tb_ptp_cfg_seq;
    logic        clk = 1'b0, rst = 1'b1;
    logic        start_i = 1'b0, master_i = 1'b0;
    logic        host_req_i = 1'b0, host_wr_i = 1'b0;
    logic [15:0] host_addr_i = 16'h0;
    logic [31:0] host_wdata_i = 32'h0;
    logic        host_ack_o, reg_req_o, reg_wr_o, reg_ack_i, seq_busy_o, seq_done_o, seq_err_o;
    logic [31:0] host_rdata_o, reg_wdata_o, reg_rdata_i;
    logic [15:0] reg_addr_o;

    ptp_cfg_seq dut (
        .bus2ip_clk(clk), .bus2ip_rst(rst), .start_i(start_i), .master_i(master_i),
        .host_req_i(host_req_i), .host_wr_i(host_wr_i), .host_addr_i(host_addr_i),
        .host_wdata_i(host_wdata_i), .host_ack_o(host_ack_o), .host_rdata_o(host_rdata_o),
        .reg_req_o(reg_req_o), .reg_wr_o(reg_wr_o), .reg_addr_o(reg_addr_o),
        .reg_wdata_o(reg_wdata_o), .reg_ack_i(reg_ack_i), .reg_rdata_i(reg_rdata_i),
        .seq_busy_o(seq_busy_o), .seq_done_o(seq_done_o), .seq_err_o(seq_err_o)
    );

    always #5 clk = ~clk;

    localparam logic [48:0] SEQ_EXP [6] = '{
        {1'b1, 16'h0100, 32'h0000_0001}, {1'b1, 16'h0204, 32'h1999_999a},
        {1'b1, 16'h0208, 32'h1234_5678}, {1'b1, 16'h020c, 32'h0000_3ccc},
        {1'b1, 16'h0210, 32'hcccc_cccc}, {1'b1, 16'h0200, 32'h0000_0001}};

    typedef struct { logic m; int dly; int n; } seq_vec_t;
    typedef struct { logic wr; logic [15:0] a; logic [31:0] d; logic [31:0] rd; } host_vec_t;

    int          checks = 0, fails = 0, nwr = 0, ack_dly = 3, cnt = 0, low = 0;
    logic [15:0] block_addr = 16'hffff;
    logic        spur = 1'b0, prev_req = 1'b0, prev_seq = 1'b0;
    logic [48:0] exp_q [$];
    logic [31:0] mem [logic [15:0]];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Core model: acks after ack_dly cycles, stores writes, scoreboards every access
    initial begin
        reg_ack_i = 1'b0;
        reg_rdata_i = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                reg_ack_i = 1'b0; cnt = 0; prev_seq = 1'b0; prev_req = 1'b0; low = 0;
            end else begin
                reg_ack_i = 1'b0;
                if (!reg_req_o) begin
                    low++; cnt = 0;
                    if (!seq_busy_o) prev_seq = 1'b0;
                    if (spur) begin reg_ack_i = 1'b1; spur = 1'b0; end
                end else begin
                    if (!prev_req) begin
                        if (seq_busy_o && prev_seq) chk("seq_gap", low, 2);
                        low = 0;
                    end
                    cnt++;
                    if (cnt >= ack_dly && reg_addr_o != block_addr) begin
                        reg_ack_i = 1'b1;
                        nwr++;
                        prev_seq = seq_busy_o;
                        if (exp_q.size() == 0) chk("unexpected_access", {reg_wr_o, reg_addr_o, reg_wdata_o}, 49'h0);
                        else chk("reg_access", {reg_wr_o, reg_addr_o, reg_wdata_o}, exp_q.pop_front());
                        if (reg_wr_o) mem[reg_addr_o] = reg_wdata_o;
                        else reg_rdata_i = mem.exists(reg_addr_o) ? mem[reg_addr_o] : 32'h0;
                    end
                end
                prev_req = reg_req_o;
            end
        end
    end

    task automatic push_seq(input logic m);
        for (int i = 0; i < (m ? 6 : 2); i++) exp_q.push_back(SEQ_EXP[i]);
    endtask

    task automatic pulse_start(input logic m);
        @(negedge clk);
        start_i = 1'b1; master_i = m;
        @(negedge clk);
        start_i = 1'b0; master_i = 1'b0;
    endtask

    task automatic wait_end();
        logic got = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (seq_done_o || seq_err_o) begin got = 1'b1; break; end
        end
        chk("seq_end_seen", got, 1);
    endtask

    task automatic host_xfer(input logic wr, input logic [15:0] a, input logic [31:0] d,
                             input logic [31:0] exp_rd, input logic exp_done);
        logic got = 1'b0;
        @(negedge clk);
        exp_q.push_back({wr, a, d});
        host_req_i = 1'b1; host_wr_i = wr; host_addr_i = a; host_wdata_i = d;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (host_ack_o) begin got = 1'b1; break; end
        end
        chk("host_ack_seen", got, 1);
        if (got) begin
            chk("host_rdata", host_rdata_o, exp_rd);
            chk("host_ack_vs_done", seq_done_o, exp_done);
        end
        host_req_i = 1'b0;
        @(negedge clk);
        chk("host_ack_pulse", host_ack_o, 0);
    endtask

    task automatic wait_addr(input logic [15:0] a);
        logic got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (reg_req_o && reg_addr_o == a) begin got = 1'b1; break; end
        end
        chk("step_reached", got, 1);
    endtask

    initial begin
        seq_vec_t  sv [4];
        host_vec_t hv [5];
        int        n;
        sv[0] = '{1'b1, 3, 6}; sv[1] = '{1'b0, 3, 2}; sv[2] = '{1'b1, 1, 6}; sv[3] = '{1'b0, 5, 2};
        hv[0] = '{1'b1, 16'h0300, 32'hdead_beef, 32'h0};
        hv[1] = '{1'b0, 16'h0300, 32'h0, 32'hdead_beef};
        hv[2] = '{1'b0, 16'h0204, 32'h0, 32'h1999_999a};
        hv[3] = '{1'b0, 16'h0210, 32'h0, 32'hcccc_cccc};
        hv[4] = '{1'b1, 16'h0204, 32'haaaa_5555, 32'h0};

        repeat (3) @(negedge clk);
        chk("rst_reg_side", {reg_req_o, reg_wr_o, reg_addr_o, reg_wdata_o}, 0);
        chk("rst_host_seq", {host_ack_o, host_rdata_o, seq_busy_o, seq_done_o, seq_err_o}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        foreach (sv[k]) begin
            nwr = 0; ack_dly = sv[k].dly;
            push_seq(sv[k].m);
            pulse_start(sv[k].m);
            chk("busy_after_start", seq_busy_o, 1);
            wait_end();
            chk("seq_done", {seq_done_o, seq_err_o, seq_busy_o, reg_req_o}, 4'b1000);
            chk("seq_write_count", nwr, sv[k].n);
            chk("seq_queue_empty", exp_q.size(), 0);
        end

        ack_dly = 3;
        foreach (hv[k]) host_xfer(hv[k].wr, hv[k].a, hv[k].d, hv[k].rd, 1'b1);

        spur = 1'b1; n = 0;
        for (int i = 0; i < 4; i++) begin @(negedge clk); n += int'(host_ack_o) + int'(seq_busy_o); end
        chk("spurious_ack_ignored", {n[7:0], seq_done_o, reg_req_o}, {8'd0, 2'b10});

        nwr = 0;
        push_seq(1'b1);
        pulse_start(1'b1);
        repeat (5) @(negedge clk);
        pulse_start(1'b0);
        wait_end();
        repeat (20) @(negedge clk);
        chk("start_while_busy_ignored", nwr, 6);
        chk("busy_start_queue", exp_q.size(), 0);

        nwr = 0;
        push_seq(1'b1);
        pulse_start(1'b1);
        wait_addr(16'h0208);
        host_xfer(1'b0, 16'h0204, 32'h0, 32'h1999_999a, 1'b1);
        chk("host_during_seq_count", nwr, 7);

        nwr = 0;
        push_seq(1'b0);
        fork
            host_xfer(1'b1, 16'h0300, 32'h5555_aaaa, 32'h0, 1'b1);
            pulse_start(1'b0);
        join
        chk("start_and_host_count", nwr, 3);

        nwr = 0; ack_dly = 6;
        fork
            host_xfer(1'b1, 16'h0304, 32'h1111_2222, 32'h0, 1'b1);
            begin repeat (2) @(negedge clk); push_seq(1'b1); pulse_start(1'b1); end
        join
        wait_end();
        chk("latched_start_done", {seq_done_o, seq_err_o}, 2'b10);
        chk("latched_start_count", nwr, 7);
        ack_dly = 3;

        block_addr = 16'h0204; n = 0;
        exp_q.push_back(SEQ_EXP[0]);
        pulse_start(1'b1);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (seq_err_o) break;
            if (reg_req_o && reg_addr_o == 16'h0204) n++;
        end
        chk("timeout_cycles", n, 1024);
        chk("timeout_state", {seq_err_o, seq_done_o, seq_busy_o, reg_req_o}, 4'b1000);
        block_addr = 16'hffff;
        host_xfer(1'b0, 16'h0100, 32'h0, 32'h0000_0001, 1'b0);

        ack_dly = 10;
        push_seq(1'b1);
        pulse_start(1'b1);
        wait_addr(16'h020c);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_reg_side", {reg_req_o, reg_wr_o, reg_addr_o, reg_wdata_o}, 0);
        chk("midrst_host_seq", {host_ack_o, host_rdata_o, seq_busy_o, seq_done_o, seq_err_o}, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0; n = 0;
        for (int i = 0; i < 10; i++) begin @(negedge clk); n += int'(reg_req_o) + int'(seq_busy_o); end
        chk("no_resume_after_rst", n, 0);
        nwr = 0; ack_dly = 3;
        push_seq(1'b1);
        pulse_start(1'b1);
        wait_end();
        chk("rerun_done", {seq_done_o, seq_err_o}, 2'b10);
        chk("rerun_count", nwr, 6);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
